cpu_run_ctrl: RTL and testbench

//  Run/step sequencer between the board buttons and the MIPS CPU core. Debounces the raw Go/Step

---
 rtl/cpu_run_ctrl_if.sv | 25 ++
 rtl/cpu_run_ctrl.sv | 174 +++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Board/CPU-facing signal bundle of the run/step sequencer.
// master = sequencer side (drives CPU_Tick and status), slave = board/CPU side.
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             Go_btn;
  logic             Step_btn;
  logic             Halt;
  logic [31:0]      PC;
  logic [31:0]      BP_Addr;
  logic             CPU_Tick;
  logic             Running;
  logic             HaltedFlag;
  logic [CNT_W-1:0] CycleCount;

  modport master (
    input  Go_btn, Step_btn, Halt, PC, BP_Addr,
    output CPU_Tick, Running, HaltedFlag, CycleCount
  );

  modport slave (
    output Go_btn, Step_btn, Halt, PC, BP_Addr,
    input  CPU_Tick, Running, HaltedFlag, CycleCount
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer: debounced Go/Step buttons, IDLE/RUN/HALTED FSM, divided CPU_Tick, tick counter.
// Optional PC breakpoint enabled by defining CPU_CTRL_BREAK_EN.
module cpu_run_ctrl #(
  parameter int TICK_DIV     = 1500000,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int CNT_W        = 32
) (
  input  logic           FPGA_GlobalClock,
  input  logic           RST_n,
  cpu_run_ctrl_if.master bus
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CYC);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       w_raw;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [DEB_W-1:0] r_deb_cnt [2];
  logic [1:0]       r_press;
  logic             w_go_p;
  logic             w_step_p;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic             r_tick;
  logic             w_tick_nxt;
  logic             r_running;
  logic             r_halted;
  logic [CNT_W-1:0] r_cnt;
`ifdef CPU_CTRL_BREAK_EN
  logic             r_bp_skip;
  logic             w_skip_nxt;
`else
  logic             w_unused;
  assign w_unused = &{1'b0, bus.PC, bus.BP_Addr};
`endif

  // Index 0 = Go, index 1 = Step.
  assign w_raw    = {bus.Step_btn, bus.Go_btn};
  assign w_go_p   = r_press[0];
  assign w_step_p = r_press[1];

  // Button synchronizers and debounce; the counter saturates so a held button pulses only once.
  always_ff @(posedge FPGA_GlobalClock or negedge RST_n) begin
    if (!RST_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_press <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_deb_cnt[i] <= {DEB_W{1'b0}};
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        if (!r_sync2[i]) begin
          r_deb_cnt[i] <= {DEB_W{1'b0}};
          r_press[i]   <= 1'b0;
        end else if (r_deb_cnt[i] < DEB_MAX) begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
          r_press[i]   <= (r_deb_cnt[i] == DEB_LAST);
        end else begin
          r_press[i]   <= 1'b0;
        end
      end
    end
  end

  // Next-state, divider and tick decision; Halt outranks a due tick, go_p outranks step_p.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = 1'b0;
    w_div_nxt   = r_div;
`ifdef CPU_CTRL_BREAK_EN
    w_skip_nxt  = r_bp_skip;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_go_p) begin
          w_state_nxt = ST_RUN;
          w_div_nxt   = {DIV_W{1'b0}};
        end else if (w_step_p) begin
          w_tick_nxt  = 1'b1;
        end else begin
          w_tick_nxt  = 1'b0;
        end
      end
      ST_RUN: begin
        if (bus.Halt) begin
          w_state_nxt = ST_HALTED;
          w_div_nxt   = {DIV_W{1'b0}};
        end else if (r_div == DIV_LAST) begin
          w_div_nxt   = {DIV_W{1'b0}};
`ifdef CPU_CTRL_BREAK_EN
          // The first tick after a resume executes the breakpoint instruction itself.
          if (r_bp_skip || (bus.PC != bus.BP_Addr)) begin
            w_tick_nxt  = 1'b1;
            w_skip_nxt  = 1'b0;
          end else begin
            w_state_nxt = ST_HALTED;
          end
`else
          w_tick_nxt  = 1'b1;
`endif
        end else begin
          w_div_nxt   = r_div + DIV_W'(1);
        end
      end
      ST_HALTED: begin
        if (w_go_p) begin
          if (!bus.Halt) begin
            w_state_nxt = ST_RUN;
            w_div_nxt   = {DIV_W{1'b0}};
`ifdef CPU_CTRL_BREAK_EN
            w_skip_nxt  = 1'b1;
`endif
          end else begin
            w_state_nxt = ST_HALTED;
          end
        end else if (w_step_p) begin
          w_tick_nxt  = 1'b1;
        end else begin
          w_tick_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_div_nxt   = {DIV_W{1'b0}};
      end
    endcase
  end

  // State, registered outputs and retired-tick counter.
  always_ff @(posedge FPGA_GlobalClock or negedge RST_n) begin
    if (!RST_n) begin
      r_state   <= ST_IDLE;
      r_div     <= {DIV_W{1'b0}};
      r_tick    <= 1'b0;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
      r_cnt     <= {CNT_W{1'b0}};
`ifdef CPU_CTRL_BREAK_EN
      r_bp_skip <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_tick    <= w_tick_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_halted  <= (w_state_nxt == ST_HALTED);
      r_cnt     <= r_cnt + CNT_W'(r_tick);
`ifdef CPU_CTRL_BREAK_EN
      r_bp_skip <= w_skip_nxt;
`endif
    end
  end

  assign bus.CPU_Tick   = r_tick;
  assign bus.Running    = r_running;
  assign bus.HaltedFlag = r_halted;
  assign bus.CycleCount = r_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: expected ticks (timing relative to RUN entry) are queued
// as buttons are driven and checked as CPU_Tick pulses appear.
module tb_cpu_run_ctrl;

  localparam int TICK_DIV = 5;
  localparam int DEB      = 4;
  localparam int CNT_W    = 8;
  localparam logic [31:0] BP = 32'h0040_0008;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

  cpu_run_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .DEBOUNCE_CYC(DEB),
    .CNT_W       (CNT_W)
  ) dut (
    .FPGA_GlobalClock(clk),
    .RST_n           (rst_n),
    .bus             (bus)
  );

  int   n_tests   = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   run_ref   = 0;
  int   exp_cnt   = 0;
  int   sb_q[$];
  logic prev_tick = 1'b0;
  logic prev_run  = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Tick monitor: pops one expectation per pulse; offset < 0 means step tick (timing unchecked).
  always @(negedge clk) begin
    int off;
    if (bus.Running && !prev_run) run_ref = cyc;
    if (bus.CPU_Tick) begin
      check("back_to_back", {31'b0, prev_tick}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_tick", {31'b0, bus.CPU_Tick}, 32'd0);
      end else begin
        off = sb_q.pop_front();
        if (off >= 0) check("tick_time", 32'(cyc - run_ref), 32'(off));
        check("cnt_at_tick", 32'(bus.CycleCount), 32'(exp_cnt % 256));
        exp_cnt = (exp_cnt + 1) % 256;
      end
    end
    prev_tick = bus.CPU_Tick;
    prev_run  = bus.Running;
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic go, input logic stp);
    bus.Go_btn   = go;
    bus.Step_btn = stp;
    step(12);
    bus.Go_btn   = 1'b0;
    bus.Step_btn = 1'b0;
    step(4);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb_q.delete();
    exp_cnt = 0;
    step(3);
    rst_n = 1'b1;
    step(2);
  endtask

  initial begin
    bus.Go_btn   = 1'b0;
    bus.Step_btn = 1'b0;
    bus.Halt     = 1'b0;
    bus.BP_Addr  = BP;
`ifdef CPU_CTRL_BREAK_EN
    bus.PC       = 32'h0040_0000;
`else
    bus.PC       = BP;
`endif

    // Reset held while buttons toggle
    for (int i = 0; i < 6; i++) begin
      bus.Go_btn   = i[0];
      bus.Step_btn = ~i[0];
      step();
      check("rst_outs", {20'b0, bus.CPU_Tick, bus.Running, bus.HaltedFlag, 1'b0, bus.CycleCount}, 32'd0);
    end
    bus.Go_btn   = 1'b0;
    bus.Step_btn = 1'b0;
    step(4);
    rst_n = 1'b1;
    step(50);
    check("idle_status", {30'b0, bus.Running, bus.HaltedFlag}, 32'd0);

    // Bouncing Go then a clean hold: one go_p, ticks every TICK_DIV from RUN entry
    for (int k = 1; k <= 3; k++) sb_q.push_back(k * TICK_DIV);
    for (int b = 0; b < 2; b++) begin
      bus.Go_btn = 1'b1; step(2);
      bus.Go_btn = 1'b0; step(2);
    end
    step(4);
    check("bounce_rejected", {31'b0, bus.Running}, 32'd0);
    bus.Go_btn = 1'b1;
    step(20);
    bus.Go_btn = 1'b0;
    check("go_running", {31'b0, bus.Running}, 32'd1);
    wait_drain(40);

    // Halt during the decision cycle of the 4th tick
    while (cyc < run_ref + 4 * TICK_DIV - 1 && cyc < 100000) step();
    bus.Halt = 1'b1;
    step();
    check("halt_flag", {30'b0, bus.Running, bus.HaltedFlag}, 32'd1);
    press(1'b1, 1'b0);
    check("go_while_halt", {30'b0, bus.Running, bus.HaltedFlag}, 32'd1);
    bus.Halt = 1'b0;
    step();
    sb_q.push_back(TICK_DIV);
    sb_q.push_back(2 * TICK_DIV);
    press(1'b1, 1'b0);
    check("resume_running", {30'b0, bus.Running, bus.HaltedFlag}, 32'd2);
    wait_drain(40);
    do_reset();

    // Three single-step ticks from IDLE
    for (int s = 0; s < 3; s++) begin
      sb_q.push_back(-1);
      press(1'b0, 1'b1);
      wait_drain(20);
    end
    step();
    check("step_count", 32'(bus.CycleCount), 32'd3);
    check("step_idle", {30'b0, bus.Running, bus.HaltedFlag}, 32'd0);

    // Go+Step together: RUN only; then run until the counter wraps to 0
    for (int k = 1; k <= 253; k++) sb_q.push_back(k * TICK_DIV);
    press(1'b1, 1'b1);
    check("gostep_running", {31'b0, bus.Running}, 32'd1);
    wait_drain(1400);
    step();
    check("wrap_count", 32'(bus.CycleCount), 32'd0);
    step(2);
    rst_n = 1'b0;
    #1;
    check("midrun_reset", {20'b0, bus.CPU_Tick, bus.Running, bus.HaltedFlag, 1'b0, bus.CycleCount}, 32'd0);
    sb_q.delete();
    exp_cnt = 0;
    step(3);
    rst_n = 1'b1;
    step(20);
    check("post_reset_idle", {30'b0, bus.Running, bus.HaltedFlag}, 32'd0);

`ifdef CPU_CTRL_BREAK_EN
    // Breakpoint: due tick at PC==BP_Addr is suppressed, resume executes it once
    bus.PC = BP;
    press(1'b1, 1'b0);
    check("bp_halted", {30'b0, bus.Running, bus.HaltedFlag}, 32'd1);
    sb_q.push_back(TICK_DIV);
    press(1'b1, 1'b0);
    wait_drain(30);
    step(6);
    check("bp_rehalted", {30'b0, bus.Running, bus.HaltedFlag}, 32'd1);
    check("bp_count", 32'(bus.CycleCount), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
